// File: rtl/mips_pkg.sv
// Shared decode types for the MIPS ID stage.
// Opcodes, ALU-op encoding and the ID/EX control bundle.
package mips_pkg;

    localparam int REG_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef struct packed {
        logic    reg_write;
        logic    reg_dst;
        logic    mem_to_reg;
        logic    mem_read;
        logic    mem_write;
        logic    alu_src;
        alu_op_t alu_op;
    } id_ctrl_t;

    localparam id_ctrl_t CTRL_BUBBLE = '0;

    // Register index 0 never creates a dependence.
    function automatic logic reg_match(
        input logic [REG_W-1:0] dst,
        input logic [REG_W-1:0] src
    );
        return (dst != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32-entry register file: two combinational reads with
// write-through, one synchronous write, r0 hardwired to zero.
module reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] a_data,
    output logic [DATA_W-1:0] b_data
);

    logic [DATA_W-1:0] regs [2**ADDR_W];
    logic              wr;

    assign wr = we && (waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                regs[i] <= '0;
            end
        end else if (wr) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        a_data = regs[a_addr];
        b_data = regs[b_addr];
        if (wr && waddr == a_addr) a_data = wdata;
        if (wr && waddr == b_addr) b_data = wdata;
        if (a_addr == '0) a_data = '0;
        if (b_addr == '0) b_data = '0;
    end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: control decode, early beq/j
// resolution, hazard detection and the ID/EX pipeline register.
module id_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           inst_in,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  mem_reg_write,
    input  logic                  mem_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_dst,
    input  logic [DATA_W-1:0]     mem_alu_result,
    output logic                  stall,
    output logic                  flush_if,
    output logic                  pc_sel_branch,
    output logic [DATA_W-1:0]     branch_target,
    output logic                  pc_sel_jump,
    output logic [DATA_W-1:0]     jump_target,
    output logic                  ex_reg_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_alu_src,
    output logic [1:0]            ex_alu_op,
    output logic [DATA_W-1:0]     ex_rs_data,
    output logic [DATA_W-1:0]     ex_rt_data,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_dst
);

    logic [5:0]            op;
    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic [DATA_W-1:0]     imm;
    logic [DATA_W-1:0]     rs_val, rt_val;
    logic [DATA_W-1:0]     cmp_a, cmp_b;
    id_ctrl_t              ctrl;
    logic                  is_beq, is_j, rt_used;
    logic                  load_use, br_haz;
    logic                  fwd_ok;

    assign op  = inst_in[31:26];
    assign rs  = inst_in[25:21];
    assign rt  = inst_in[20:16];
    assign rd  = inst_in[15:11];
    assign imm = {{(DATA_W-16){inst_in[15]}}, inst_in[15:0]};

    reg_file #(
        .DATA_W(DATA_W),
        .ADDR_W(REG_ADDR_W)
    ) u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (wb_we),
        .waddr (wb_addr),
        .wdata (wb_data),
        .a_addr(rs),
        .b_addr(rt),
        .a_data(rs_val),
        .b_data(rt_val)
    );

    always_comb begin
        ctrl = CTRL_BUBBLE;
        unique case (1'b1)
            op == OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            op == OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
            end
            op == OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            op == OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            op == OP_BEQ: begin
                ctrl.alu_op = ALU_SUB;
            end
            default: ;
        endcase
    end

    assign is_beq  = (op == OP_BEQ);
    assign is_j    = (op == OP_J);
    assign rt_used = (op == OP_RTYPE) || (op == OP_SW) || is_beq;

    // The rs field of a jump is target bits, so it never forms a hazard.
    assign load_use = ex_mem_read && !is_j &&
                      (reg_match(ex_dst, rs) ||
                       (rt_used && reg_match(ex_dst, rt)));

    assign br_haz = is_beq &&
                    ((ex_reg_write &&
                      (reg_match(ex_dst, rs) || reg_match(ex_dst, rt))) ||
                     (mem_mem_read &&
                      (reg_match(mem_dst, rs) || reg_match(mem_dst, rt))));

    assign stall = load_use || br_haz;

    assign fwd_ok = mem_reg_write && !mem_mem_read;
    assign cmp_a  = (fwd_ok && reg_match(mem_dst, rs)) ? mem_alu_result : rs_val;
    assign cmp_b  = (fwd_ok && reg_match(mem_dst, rt)) ? mem_alu_result : rt_val;

    assign pc_sel_branch = is_beq && (cmp_a == cmp_b) && !stall;
    assign pc_sel_jump   = is_j && !stall;
    assign flush_if      = pc_sel_branch || pc_sel_jump;

    assign branch_target = pc_in + {imm[DATA_W-3:0], 2'b00};
    assign jump_target   = {pc_in[DATA_W-1:DATA_W-4], inst_in[25:0], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_alu_op     <= 2'b00;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_pc         <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_dst        <= '0;
        end else begin
            if (stall) begin
                ex_reg_write  <= 1'b0;
                ex_mem_to_reg <= 1'b0;
                ex_mem_read   <= 1'b0;
                ex_mem_write  <= 1'b0;
                ex_alu_src    <= 1'b0;
                ex_alu_op     <= 2'b00;
            end else begin
                ex_reg_write  <= ctrl.reg_write;
                ex_mem_to_reg <= ctrl.mem_to_reg;
                ex_mem_read   <= ctrl.mem_read;
                ex_mem_write  <= ctrl.mem_write;
                ex_alu_src    <= ctrl.alu_src;
                ex_alu_op     <= ctrl.alu_op;
            end
            ex_rs_data <= rs_val;
            ex_rt_data <= rt_val;
            ex_imm     <= imm;
            ex_pc      <= pc_in;
            ex_rs      <= rs;
            ex_rt      <= rt;
            ex_dst     <= ctrl.reg_dst ? rd : rt;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table,
// hand-written hazard sequences and a randomized reference model.
module tb_id_stage;

    localparam logic [31:0] NOP = 32'hFC000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_in, pc_in;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mem_reg_write, mem_mem_read;
    logic [4:0]  mem_dst;
    logic [31:0] mem_alu_result;
    logic        stall, flush_if, pc_sel_branch, pc_sel_jump;
    logic [31:0] branch_target, jump_target;
    logic        ex_reg_write, ex_mem_to_reg, ex_mem_read;
    logic        ex_mem_write, ex_alu_src;
    logic [1:0]  ex_alu_op;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc;
    logic [4:0]  ex_rs, ex_rt, ex_dst;

    id_stage dut (
        .clk(clk), .rst(rst), .inst_in(inst_in), .pc_in(pc_in),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_dst(mem_dst), .mem_alu_result(mem_alu_result),
        .stall(stall), .flush_if(flush_if),
        .pc_sel_branch(pc_sel_branch), .branch_target(branch_target),
        .pc_sel_jump(pc_sel_jump), .jump_target(jump_target),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] rt_i(input logic [4:0] s, t, d);
        return {6'h00, s, t, d, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_i(input logic [5:0] op,
                                        input logic [4:0] s, t,
                                        input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    task automatic drive(input logic [31:0] i, input logic [31:0] p);
        inst_in = i; pc_in = p;
        wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        mem_reg_write = 1'b0; mem_mem_read = 1'b0;
        mem_dst = 5'd0; mem_alu_result = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(NOP, 32'd0);
        step();
        rst = 1'b0;
    endtask

    function automatic logic [6:0] ex_ctl();
        return {ex_reg_write, ex_mem_to_reg, ex_mem_read,
                ex_mem_write, ex_alu_src, ex_alu_op};
    endfunction

    typedef struct {
        logic [31:0] inst, pc;
        logic        wbwe;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        mrw, mmr;
        logic [4:0]  mdst;
        logic [31:0] mres;
        logic        stall, psb, psj;
        logic [31:0] bt;
        logic [6:0]  ctl;
        logic [4:0]  dst;
        logic [31:0] imm, rsd;
    } vec_t;

    vec_t vecs [12];

    // reference model state
    logic [31:0] m_regs [32];
    logic        m_rw, m_m2r, m_mr, m_mw, m_as, m_dk;
    logic [1:0]  m_aop;
    logic [4:0]  m_rs, m_rt, m_dst;
    logic [31:0] m_rsd, m_rtd, m_imm, m_pc;

    logic [31:0] r_inst;
    logic [5:0]  r_op;
    logic [4:0]  r_s, r_t, r_d;
    logic [15:0] r_im;
    logic        e_rw, e_m2r, e_mr, e_mw, e_as, e_rd, e_rtu;
    logic [1:0]  e_aop;
    logic        e_lu, e_bh, e_st, e_psb, e_psj;
    logic [31:0] e_a, e_b, e_sx, e_bt, e_jt;
    logic signed [15:0] r_si;

    function automatic logic [31:0] rv(input logic [4:0] x);
        if (x == 5'd0) return 32'd0;
        if (wb_we && wb_addr == x) return wb_data;
        return m_regs[x];
    endfunction

    task automatic model_eval();
        r_op = inst_in[31:26];
        r_s  = inst_in[25:21];
        r_t  = inst_in[20:16];
        r_d  = inst_in[15:11];
        {e_rw, e_m2r, e_mr, e_mw, e_as, e_rd, e_aop} = '0;
        case (r_op)
            6'h00: begin e_rw = 1; e_rd = 1; e_aop = 2'b10; end
            6'h23: begin e_rw = 1; e_mr = 1; e_m2r = 1; e_as = 1; end
            6'h2B: begin e_mw = 1; e_as = 1; end
            6'h08: begin e_rw = 1; e_as = 1; end
            6'h04: e_aop = 2'b01;
            default: ;
        endcase
        e_rtu = (r_op == 6'h00) || (r_op == 6'h2B) || (r_op == 6'h04);
        e_lu = (r_op != 6'h02) && m_mr && m_dst != 0 &&
               (m_dst == r_s || (e_rtu && m_dst == r_t));
        e_bh = (r_op == 6'h04) &&
               ((m_rw && m_dst != 0 && (m_dst == r_s || m_dst == r_t)) ||
                (mem_mem_read && mem_dst != 0 &&
                 (mem_dst == r_s || mem_dst == r_t)));
        e_st = e_lu || e_bh;
        e_a = (mem_reg_write && !mem_mem_read && mem_dst != 0 &&
               mem_dst == r_s) ? mem_alu_result : rv(r_s);
        e_b = (mem_reg_write && !mem_mem_read && mem_dst != 0 &&
               mem_dst == r_t) ? mem_alu_result : rv(r_t);
        e_psb = (r_op == 6'h04) && (e_a == e_b) && !e_st;
        e_psj = (r_op == 6'h02) && !e_st;
        r_si = inst_in[15:0];
        e_sx = 32'(r_si);
        e_bt = pc_in + e_sx * 4;
        e_jt = {pc_in[31:28], inst_in[25:0], 2'b00};
    endtask

    task automatic model_clock();
        if (e_st) {m_rw, m_m2r, m_mr, m_mw, m_as, m_aop} = '0;
        else {m_rw, m_m2r, m_mr, m_mw, m_as, m_aop} =
             {e_rw, e_m2r, e_mr, e_mw, e_as, e_aop};
        m_dk  = !e_st;
        m_rs  = r_s;
        m_rt  = r_t;
        m_dst = e_rd ? r_d : r_t;
        m_rsd = rv(r_s);
        m_rtd = rv(r_t);
        m_imm = e_sx;
        m_pc  = pc_in;
        if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
    endtask

    initial begin
        // inst, pc, wbwe, wba, wbd, mrw, mmr, mdst, mres,
        // stall, psb, psj, bt, ctl, dst, imm, rsd
        vecs[0]  = '{rt_i(5, 0, 1), 32'h100, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0,
                     0, 0, 0, 32'h2180, 7'b1000010, 1, 32'h820, 32'hDEADBEEF};
        vecs[1]  = '{i_i(6'h23, 3, 2, 16'h8), 32'h100, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 32'h120, 7'b1110100, 2, 32'h8, 0};
        vecs[2]  = '{i_i(6'h2B, 3, 2, 16'hFFFC), 32'h100, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 32'hF0, 7'b0001100, 2, 32'hFFFFFFFC, 0};
        vecs[3]  = '{i_i(6'h08, 0, 7, 16'hFFFF), 32'h100, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 32'hFC, 7'b1000100, 7, 32'hFFFFFFFF, 0};
        vecs[4]  = '{i_i(6'h04, 1, 2, 16'h4), 32'h100, 0, 0, 0, 0, 0, 0, 0,
                     0, 1, 0, 32'h110, 7'b0000001, 2, 32'h4, 0};
        vecs[5]  = '{i_i(6'h04, 1, 2, 16'h4), 32'h100, 0, 0, 0, 1, 0, 1, 5,
                     0, 0, 0, 32'h110, 7'b0000001, 2, 32'h4, 0};
        vecs[6]  = '{i_i(6'h04, 1, 2, 16'h4), 32'h100, 0, 0, 0, 0, 1, 2, 0,
                     1, 0, 0, 32'h110, 7'b0000000, 2, 32'h4, 0};
        vecs[7]  = '{{6'h02, 26'h10}, 32'h40000004, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 1, 32'h40000044, 7'b0000000, 0, 32'h10, 0};
        vecs[8]  = '{i_i(6'h0D, 1, 2, 16'h1234), 32'h100, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 32'h49D0, 7'b0000000, 2, 32'h1234, 0};
        vecs[9]  = '{i_i(6'h04, 0, 0, 16'hFFFF), 32'h100, 0, 0, 0, 0, 0, 0, 0,
                     0, 1, 0, 32'hFC, 7'b0000001, 0, 32'hFFFFFFFF, 0};
        vecs[10] = '{rt_i(5, 0, 1), 32'h100, 0, 0, 0, 0, 1, 5, 0,
                     0, 0, 0, 32'h2180, 7'b1000010, 1, 32'h820, 0};
        vecs[11] = '{i_i(6'h04, 0, 0, 16'hFFFF), 32'h100, 0, 0, 0, 0, 1, 0, 0,
                     0, 1, 0, 32'hFC, 7'b0000001, 0, 32'hFFFFFFFF, 0};

        rst = 1'b1;
        drive(NOP, 32'd0);
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ctl", {25'd0, ex_ctl()}, 32'd0);
        chk("reset_dst", {27'd0, ex_dst}, 32'd0);
        chk("reset_imm", ex_imm, 32'd0);
        chk("reset_pc", ex_pc, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            do_reset();
            drive(vecs[i].inst, vecs[i].pc);
            wb_we = vecs[i].wbwe; wb_addr = vecs[i].wba;
            wb_data = vecs[i].wbd;
            mem_reg_write = vecs[i].mrw; mem_mem_read = vecs[i].mmr;
            mem_dst = vecs[i].mdst; mem_alu_result = vecs[i].mres;
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].stall});
            chk($sformatf("v%0d_psb", i), {31'd0, pc_sel_branch}, {31'd0, vecs[i].psb});
            chk($sformatf("v%0d_psj", i), {31'd0, pc_sel_jump}, {31'd0, vecs[i].psj});
            chk($sformatf("v%0d_flush", i), {31'd0, flush_if},
                {31'd0, vecs[i].psb | vecs[i].psj});
            chk($sformatf("v%0d_bt", i), branch_target, vecs[i].bt);
            chk($sformatf("v%0d_jt", i), jump_target,
                {vecs[i].pc[31:28], vecs[i].inst[25:0], 2'b00});
            step();
            chk($sformatf("v%0d_ctl", i), {25'd0, ex_ctl()}, {25'd0, vecs[i].ctl});
            if (!vecs[i].stall) begin
                chk($sformatf("v%0d_dst", i), {27'd0, ex_dst}, {27'd0, vecs[i].dst});
                chk($sformatf("v%0d_imm", i), ex_imm, vecs[i].imm);
                chk($sformatf("v%0d_rsd", i), ex_rs_data, vecs[i].rsd);
                chk($sformatf("v%0d_pc", i), ex_pc, vecs[i].pc);
            end
        end

        // load-use: one bubble, then the add issues
        do_reset();
        drive(i_i(6'h23, 3, 2, 16'h0), 32'h200);
        step();
        drive(rt_i(2, 2, 4), 32'h204);
        @(negedge clk);
        chk("lu_stall", {31'd0, stall}, 32'd1);
        chk("lu_flush", {31'd0, flush_if}, 32'd0);
        step();
        chk("lu_bubble", {25'd0, ex_ctl()}, 32'd0);
        @(negedge clk);
        chk("lu_release", {31'd0, stall}, 32'd0);
        step();
        chk("lu_ex_rs", {27'd0, ex_rs}, 32'd2);
        chk("lu_ex_rw", {31'd0, ex_reg_write}, 32'd1);
        chk("lu_ex_dst", {27'd0, ex_dst}, 32'd4);

        // branch hazard then forwarded operand
        do_reset();
        drive(i_i(6'h08, 0, 1, 16'd9), 32'h0);
        wb_we = 1; wb_addr = 2; wb_data = 32'd9;
        step();
        drive(i_i(6'h04, 1, 2, 16'h4), 32'h100);
        @(negedge clk);
        chk("bh_stall", {31'd0, stall}, 32'd1);
        chk("bh_psb", {31'd0, pc_sel_branch}, 32'd0);
        step();
        mem_reg_write = 1; mem_dst = 1; mem_alu_result = 32'd9;
        @(negedge clk);
        chk("bf_stall", {31'd0, stall}, 32'd0);
        chk("bf_psb", {31'd0, pc_sel_branch}, 32'd1);
        chk("bf_flush", {31'd0, flush_if}, 32'd1);
        step();

        // $1=7 stored, $2=7 via same-cycle bypass
        do_reset();
        drive(NOP, 32'h0);
        wb_we = 1; wb_addr = 1; wb_data = 32'd7;
        step();
        drive(i_i(6'h04, 1, 2, 16'h4), 32'h100);
        wb_we = 1; wb_addr = 2; wb_data = 32'd7;
        @(negedge clk);
        chk("bt_psb", {31'd0, pc_sel_branch}, 32'd1);
        chk("bt_flush", {31'd0, flush_if}, 32'd1);
        chk("bt_target", branch_target, 32'h110);
        step();

        // jump plus r0 write
        drive({6'h02, 26'h10}, 32'h40000004);
        wb_we = 1; wb_addr = 0; wb_data = 32'h55;
        @(negedge clk);
        chk("j_target", jump_target, 32'h40000040);
        chk("j_psj", {31'd0, pc_sel_jump}, 32'd1);
        chk("j_flush", {31'd0, flush_if}, 32'd1);
        step();
        drive(rt_i(0, 0, 1), 32'h0);
        wb_we = 1; wb_addr = 0; wb_data = 32'h55;
        step();
        chk("r0_rs", ex_rs_data, 32'd0);
        chk("r0_rt", ex_rt_data, 32'd0);

        // reset during a stall
        do_reset();
        drive(NOP, 32'h0);
        wb_we = 1; wb_addr = 5; wb_data = 32'h1234;
        step();
        drive(i_i(6'h23, 3, 2, 16'h0), 32'h300);
        step();
        drive(rt_i(2, 2, 4), 32'h304);
        @(negedge clk);
        chk("rs_stall_pre", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rs_ctl", {25'd0, ex_ctl()}, 32'd0);
        chk("rs_idx", {17'd0, ex_rs, ex_rt, ex_dst}, 32'd0);
        chk("rs_pc", ex_pc, 32'd0);
        chk("rs_data", ex_rs_data | ex_rt_data | ex_imm, 32'd0);
        @(negedge clk);
        chk("rs_stall_post", {31'd0, stall}, 32'd0);
        drive(rt_i(5, 0, 1), 32'h0);
        step();
        chk("rs_regfile", ex_rs_data, 32'd0);

        // randomized run against the reference model
        do_reset();
        for (int j = 0; j < 32; j++) m_regs[j] = 32'd0;
        {m_rw, m_m2r, m_mr, m_mw, m_as, m_aop, m_dk} = '0;
        m_dst = 0;
        for (int n = 0; n < 1500; n++) begin
            r_s  = 5'($urandom_range(0, 7));
            r_t  = 5'($urandom_range(0, 7));
            r_d  = 5'($urandom_range(0, 7));
            r_im = 16'($urandom);
            case ($urandom_range(0, 8))
                0, 1: r_inst = {6'h00, r_s, r_t, r_d, 5'd0, 6'($urandom)};
                2, 3: r_inst = {6'h23, r_s, r_t, r_im};
                4:    r_inst = {6'h2B, r_s, r_t, r_im};
                5:    r_inst = {6'h08, r_s, r_t, r_im};
                6, 7: r_inst = {6'h04, r_s, r_t, r_im};
                default: r_inst = ($urandom_range(0, 1) == 0) ?
                                  {6'h02, 26'($urandom)} :
                                  {6'h0D, r_s, r_t, r_im};
            endcase
            drive(r_inst, $urandom);
            wb_we = 1'($urandom);
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = $urandom_range(0, 3);
            mem_reg_write = 1'($urandom);
            mem_mem_read = ($urandom_range(0, 3) == 0);
            mem_dst = 5'($urandom_range(0, 7));
            mem_alu_result = $urandom_range(0, 3);
            model_eval();
            @(negedge clk);
            chk("rnd_stall", {31'd0, stall}, {31'd0, e_st});
            chk("rnd_psb", {31'd0, pc_sel_branch}, {31'd0, e_psb});
            chk("rnd_psj", {31'd0, pc_sel_jump}, {31'd0, e_psj});
            chk("rnd_flush", {31'd0, flush_if}, {31'd0, e_psb | e_psj});
            chk("rnd_bt", branch_target, e_bt);
            chk("rnd_jt", jump_target, e_jt);
            model_clock();
            step();
            chk("rnd_ctl", {25'd0, ex_ctl()},
                {25'd0, m_rw, m_m2r, m_mr, m_mw, m_as, m_aop});
            if (m_dk) begin
                chk("rnd_idx", {17'd0, ex_rs, ex_rt, ex_dst},
                    {17'd0, m_rs, m_rt, m_dst});
                chk("rnd_rsd", ex_rs_data, m_rsd);
                chk("rnd_rtd", ex_rt_data, m_rtd);
                chk("rnd_imm", ex_imm, m_imm);
                chk("rnd_pc", ex_pc, m_pc);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
